// File: rtl/uvma_tprescaler_b_mc_pkg.sv
// Shared types, limits and helpers for the multi-channel prescaler checker.
//   upd_mode_e : how a channel picks up a new prescale value
//   err_kind_e : classification of a per-channel compare result
//   popcount   : number of set bits in a channel error vector
package uvma_tprescaler_b_mc_pkg;

  localparam int MAX_N_CH    = 16;
  localparam int MIN_LATENCY = 1;
  localparam int MAX_LATENCY = 4;
  localparam int POP_W       = $clog2(MAX_N_CH + 1);

  typedef enum logic {
    UPD_IMMEDIATE = 1'b0,
    UPD_SHADOW    = 1'b1
  } upd_mode_e;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_MISSING  = 2'd1,
    ERR_SPURIOUS = 2'd2
  } err_kind_e;

  function automatic logic [POP_W-1:0] popcount(input logic [MAX_N_CH-1:0] v);
    logic [POP_W-1:0] n;
    n = '0;
    for (int i = 0; i < MAX_N_CH; i++) n = n + POP_W'(v[i]);
    return n;
  endfunction

endpackage

// File: rtl/uvma_tprescaler_b_mc_chan_model.sv
// Reference model of one prescaler channel plus its tick compare.
// Ports:
//   clk, reset_n  clock and asynchronous active-low reset
//   en            channel enable; low clears the count and flushes expectations
//   ps_value      prescale value, divide ratio = ps_value+1
//   tick_in       input tick qualifying a count step
//   tick_out      DUT output tick under check
//   exp_tick      predicted tick, aligned with tick_out
//   missing       exp_tick high while tick_out low
//   spurious      tick_out high while exp_tick low
module uvma_tprescaler_b_mc_chan_model
  import uvma_tprescaler_b_mc_pkg::*;
#(
  parameter int        PS_W    = 8,
  parameter int        LATENCY = 1,
  parameter upd_mode_e MODE    = UPD_IMMEDIATE
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            en,
  input  logic [PS_W-1:0] ps_value,
  input  logic            tick_in,
  input  logic            tick_out,
  output logic            exp_tick,
  output logic            missing,
  output logic            spurious
);

  logic [PS_W-1:0]    cnt_q;
  logic [PS_W-1:0]    shadow_q;
  logic               en_q;
  logic [PS_W-1:0]    active_ps;
  logic               en_rise;
  logic               terminal;
  logic [LATENCY-1:0] exp_p;
  logic [LATENCY-1:0] exp_nxt;

  always_comb begin
    en_rise   = en & ~en_q;
    // On the enable-rise cycle the shadow has not been loaded yet, so the
    // live value governs that first compare.
    active_ps = (MODE == UPD_SHADOW && !en_rise) ? shadow_q : ps_value;
    // >= rather than == so a value lowered below the running count in
    // immediate mode ends the period on the next tick.
    terminal  = en & tick_in & (cnt_q >= active_ps);
  end

  always_comb begin
    exp_nxt = '0;
    if (en) begin
      exp_nxt[0] = terminal;
      for (int i = 1; i < LATENCY; i++) exp_nxt[i] = exp_p[i-1];
    end
  end

  // Stage p0..pN: count state and expectation shift register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q    <= '0;
      shadow_q <= '0;
      en_q     <= 1'b0;
      exp_p    <= '0;
    end else begin
      en_q  <= en;
      exp_p <= exp_nxt;
      if (!en)          cnt_q <= '0;
      else if (tick_in) cnt_q <= terminal ? '0 : cnt_q + PS_W'(1);
      if (en_rise || terminal) shadow_q <= ps_value;
    end
  end

  always_comb begin
    exp_tick = exp_p[LATENCY-1];
    missing  = exp_tick & ~tick_out;
    spurious = ~exp_tick & tick_out;
  end

endmodule

// File: rtl/uvma_tprescaler_b_mc_chkr.sv
// Multi-channel timer-prescaler checker: one reference model per channel,
// sticky missing/spurious flags and a shared saturating error counter.
// Ports:
//   clk, reset_n    clock and asynchronous active-low reset
//   en_i            per-channel enable
//   ps_value_i      per-channel prescale value, channel c at [c*PS_W +: PS_W]
//   tick_in_i       per-channel input tick
//   tick_out_i      per-channel DUT output tick under check
//   clr_i           synchronous clear of flags and counter
//   exp_tick_o      predicted ticks, aligned with tick_out_i
//   err_missing_o   sticky expected-tick-absent flags
//   err_spurious_o  sticky unexpected-tick flags
//   err_cnt_o       saturating total error count
module uvma_tprescaler_b_mc_chkr
  import uvma_tprescaler_b_mc_pkg::*;
#(
  parameter int N_CH     = 2,
  parameter int PS_W     = 8,
  parameter int LATENCY  = 1,
  parameter int UPD_MODE = 0,
  parameter int CNT_W    = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [N_CH-1:0]      en_i,
  input  logic [N_CH*PS_W-1:0] ps_value_i,
  input  logic [N_CH-1:0]      tick_in_i,
  input  logic [N_CH-1:0]      tick_out_i,
  input  logic                 clr_i,
  output logic [N_CH-1:0]      exp_tick_o,
  output logic [N_CH-1:0]      err_missing_o,
  output logic [N_CH-1:0]      err_spurious_o,
  output logic [CNT_W-1:0]     err_cnt_o
);

  localparam upd_mode_e MODE  = (UPD_MODE != 0) ? UPD_SHADOW : UPD_IMMEDIATE;
  localparam int        SUM_W = CNT_W + POP_W + 1;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [POP_W-1:0] b);
    logic [SUM_W-1:0] s;
    s = SUM_W'(a) + SUM_W'(b);
    if (s > SUM_W'({CNT_W{1'b1}})) return {CNT_W{1'b1}};
    return s[CNT_W-1:0];
  endfunction

  logic [N_CH-1:0]     missing;
  logic [N_CH-1:0]     spurious;
  logic [N_CH-1:0]     err_vec;
  logic [MAX_N_CH-1:0] err_pad;
  logic [POP_W-1:0]    err_pop;

  for (genvar c = 0; c < N_CH; c++) begin : g_chan
    uvma_tprescaler_b_mc_chan_model #(
      .PS_W    (PS_W),
      .LATENCY (LATENCY),
      .MODE    (MODE)
    ) u_chan (
      .clk      (clk),
      .reset_n  (reset_n),
      .en       (en_i[c]),
      .ps_value (ps_value_i[c*PS_W +: PS_W]),
      .tick_in  (tick_in_i[c]),
      .tick_out (tick_out_i[c]),
      .exp_tick (exp_tick_o[c]),
      .missing  (missing[c]),
      .spurious (spurious[c])
    );
  end

  always_comb begin
    err_vec = missing | spurious;
    err_pad = MAX_N_CH'(err_vec);
    err_pop = popcount(err_pad);
  end

  // Stage p1: sticky flags and error counter. A clear restarts from this
  // cycle's errors so nothing seen in the clear cycle is lost.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_missing_o  <= '0;
      err_spurious_o <= '0;
      err_cnt_o      <= '0;
    end else if (clr_i) begin
      err_missing_o  <= missing;
      err_spurious_o <= spurious;
      err_cnt_o      <= sat_add('0, err_pop);
    end else begin
      err_missing_o  <= err_missing_o | missing;
      err_spurious_o <= err_spurious_o | spurious;
      err_cnt_o      <= sat_add(err_cnt_o, err_pop);
    end
  end

endmodule

// File: tb/tb_uvma_tprescaler_b_mc_chkr.sv
module tb_uvma_tprescaler_b_mc_chkr;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  en_i;
  logic [15:0] ps_value_i;
  logic [1:0]  tick_in_i;
  logic [1:0]  tout0, tout1;
  logic        clr_i;
  logic [1:0]  exp0, mis0, spu0;
  logic [1:0]  exp1, mis1, spu1;
  logic [15:0] cnt0;
  logic [3:0]  cnt1;

  always #5 clk = ~clk;

  // Immediate-update, latency 1, wide counter
  uvma_tprescaler_b_mc_chkr #(
    .N_CH(2), .PS_W(8), .LATENCY(1), .UPD_MODE(0), .CNT_W(16)
  ) dut0 (
    .clk(clk), .reset_n(reset_n), .en_i(en_i), .ps_value_i(ps_value_i),
    .tick_in_i(tick_in_i), .tick_out_i(tout0), .clr_i(clr_i),
    .exp_tick_o(exp0), .err_missing_o(mis0), .err_spurious_o(spu0),
    .err_cnt_o(cnt0)
  );

  // Shadowed update, latency 2, 4-bit counter
  uvma_tprescaler_b_mc_chkr #(
    .N_CH(2), .PS_W(8), .LATENCY(2), .UPD_MODE(1), .CNT_W(4)
  ) dut1 (
    .clk(clk), .reset_n(reset_n), .en_i(en_i), .ps_value_i(ps_value_i),
    .tick_in_i(tick_in_i), .tick_out_i(tout1), .clr_i(clr_i),
    .exp_tick_o(exp1), .err_missing_o(mis1), .err_spurious_o(spu1),
    .err_cnt_o(cnt1)
  );

  // Reference model: per (instance, channel) index k = m*2+c.
  // Expected ticks are kept as a list of the cycle numbers they are due in.
  int          mcnt[4];
  int          mshadow[4];
  bit          men_prev[4];
  int          dueq[4][$];
  logic [1:0]  mflag_m[2];
  logic [1:0]  mflag_s[2];
  int          mecnt[2];
  int          cyc;
  int          n_assert = 0;
  int          n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 4; k++) begin
      mcnt[k] = 0;
      mshadow[k] = 0;
      men_prev[k] = 1'b0;
      dueq[k].delete();
    end
    for (int m = 0; m < 2; m++) begin
      mflag_m[m] = 2'b00;
      mflag_s[m] = 2'b00;
      mecnt[m] = 0;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_exp0"}, 32'(exp0), 0);
    check({tag, "_mis0"}, 32'(mis0), 0);
    check({tag, "_spu0"}, 32'(spu0), 0);
    check({tag, "_cnt0"}, 32'(cnt0), 0);
    check({tag, "_exp1"}, 32'(exp1), 0);
    check({tag, "_mis1"}, 32'(mis1), 0);
    check({tag, "_spu1"}, 32'(spu1), 0);
    check({tag, "_cnt1"}, 32'(cnt1), 0);
  endtask

  // One clock cycle: check registered outputs, drive inputs, advance model.
  // f0/f1 flip the otherwise-correct DUT tick_out per channel.
  task automatic step(input logic [1:0] en, input logic [7:0] ps0, input logic [7:0] ps1,
                      input logic [1:0] tin, input logic [1:0] f0, input logic [1:0] f1,
                      input logic clr);
    logic [1:0] e[2];
    logic [1:0] tout[2];
    for (int m = 0; m < 2; m++) begin
      for (int c = 0; c < 2; c++) begin
        int k;
        k = m * 2 + c;
        e[m][c] = (dueq[k].size() > 0) && (dueq[k][0] == cyc);
      end
    end
    check("exp0", 32'(exp0), 32'(e[0]));
    check("mis0", 32'(mis0), 32'(mflag_m[0]));
    check("spu0", 32'(spu0), 32'(mflag_s[0]));
    check("cnt0", 32'(cnt0), 32'(mecnt[0]));
    check("exp1", 32'(exp1), 32'(e[1]));
    check("mis1", 32'(mis1), 32'(mflag_m[1]));
    check("spu1", 32'(spu1), 32'(mflag_s[1]));
    check("cnt1", 32'(cnt1), 32'(mecnt[1]));

    tout[0] = e[0] ^ f0;
    tout[1] = e[1] ^ f1;
    en_i = en;
    ps_value_i = {ps1, ps0};
    tick_in_i = tin;
    clr_i = clr;
    tout0 = tout[0];
    tout1 = tout[1];

    for (int m = 0; m < 2; m++) begin
      logic [1:0] mis, spu;
      int pop, mx, lat;
      mx  = (m == 0) ? 65535 : 15;
      lat = (m == 0) ? 1 : 2;
      mis = e[m] & ~tout[m];
      spu = ~e[m] & tout[m];
      pop = $countones(mis | spu);
      if (clr) begin
        mflag_m[m] = mis;
        mflag_s[m] = spu;
        mecnt[m] = (pop > mx) ? mx : pop;
      end else begin
        mflag_m[m] = mflag_m[m] | mis;
        mflag_s[m] = mflag_s[m] | spu;
        mecnt[m] = (mecnt[m] + pop > mx) ? mx : mecnt[m] + pop;
      end
      for (int c = 0; c < 2; c++) begin
        int k, ps, act;
        bit rise, term;
        k = m * 2 + c;
        ps = (c == 0) ? int'(ps0) : int'(ps1);
        if (dueq[k].size() > 0 && dueq[k][0] == cyc) void'(dueq[k].pop_front());
        rise = en[c] && !men_prev[k];
        act = (m == 1 && !rise) ? mshadow[k] : ps;
        term = en[c] && tin[c] && (mcnt[k] >= act);
        if (!en[c]) begin
          mcnt[k] = 0;
          dueq[k].delete();
        end else if (tin[c]) begin
          mcnt[k] = term ? 0 : mcnt[k] + 1;
        end
        if (rise || term) mshadow[k] = ps;
        if (term) dueq[k].push_back(cyc + lat);
        men_prev[k] = en[c];
      end
    end

    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    reset_n = 1'b0;
    en_i = 2'b00;
    ps_value_i = '0;
    tick_in_i = 2'b00;
    tout0 = 2'b00;
    tout1 = 2'b00;
    clr_i = 1'b0;
    cyc = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Divide-by-4 on both channels, correct DUT
    repeat (20) step(2'b11, 8'd3, 8'd3, 2'b11, 2'b00, 2'b00, 1'b0);
    check("div4_cnt0", 32'(cnt0), 0);

    // Divide-by-1 on ch0, then one suppressed tick
    repeat (6) step(2'b11, 8'd0, 8'd3, 2'b11, 2'b00, 2'b00, 1'b0);
    step(2'b11, 8'd0, 8'd3, 2'b11, 2'b01, 2'b01, 1'b0);
    check("ps0_missing", 32'(mis0), 32'h1);
    check("ps0_cnt", 32'(cnt0), 32'h1);
    repeat (3) step(2'b11, 8'd0, 8'd3, 2'b11, 2'b00, 2'b00, 1'b0);
    check("ps0_missing_held", 32'(mis0), 32'h1);

    // Disabled channel with a spurious DUT tick, then clear
    step(2'b00, 8'd0, 8'd3, 2'b00, 2'b00, 2'b00, 1'b1);
    repeat (2) step(2'b00, 8'd0, 8'd3, 2'b00, 2'b00, 2'b00, 1'b0);
    step(2'b00, 8'd0, 8'd3, 2'b00, 2'b10, 2'b10, 1'b0);
    check("dis_spurious", 32'(spu0), 32'h2);
    check("dis_cnt", 32'(cnt0), 32'h1);
    step(2'b00, 8'd0, 8'd3, 2'b00, 2'b00, 2'b00, 1'b1);
    check("clr_spu", 32'(spu0), 0);
    check("clr_cnt", 32'(cnt0), 0);

    // Prescale lowered from 10 to 5 with the count at 7
    repeat (7) step(2'b11, 8'd10, 8'd10, 2'b11, 2'b00, 2'b00, 1'b0);
    step(2'b11, 8'd5, 8'd5, 2'b11, 2'b00, 2'b00, 1'b0);
    check("ps_drop_imm", 32'(exp0), 32'h3);
    repeat (24) step(2'b11, 8'd5, 8'd5, 2'b11, 2'b00, 2'b00, 1'b0);

    // Errors on both channels in a clear cycle, then counter saturation
    step(2'b11, 8'd5, 8'd5, 2'b11, 2'b11, 2'b11, 1'b1);
    check("clr_err_flags", 32'(mis0 | spu0), 32'h3);
    check("clr_err_cnt", 32'(cnt0), 32'h2);
    repeat (3) step(2'b00, 8'd5, 8'd5, 2'b00, 2'b00, 2'b00, 1'b0);
    repeat (20) step(2'b00, 8'd5, 8'd5, 2'b00, 2'b01, 2'b01, 1'b0);
    check("sat_cnt1", 32'(cnt1), 32'hF);
    check("nosat_cnt0", 32'(cnt0), 32'd22);

    // Randomised traffic
    for (int i = 0; i < 300; i++) begin
      logic [1:0] en, tin, f0, f1;
      en  = ($urandom_range(0, 9) != 0) ? 2'b11 : 2'($urandom_range(0, 3));
      tin = 2'($urandom_range(0, 3));
      f0  = {($urandom_range(0, 19) == 0), ($urandom_range(0, 19) == 0)};
      f1  = {($urandom_range(0, 19) == 0), ($urandom_range(0, 19) == 0)};
      step(en, 8'($urandom_range(0, 4)), 8'($urandom_range(0, 4)), tin, f0, f1,
           ($urandom_range(0, 24) == 0));
    end

    // Asynchronous reset at count 2 of divide-by-4
    step(2'b00, 8'd3, 8'd3, 2'b00, 2'b00, 2'b00, 1'b0);
    step(2'b11, 8'd3, 8'd3, 2'b11, 2'b11, 2'b00, 1'b0);
    step(2'b11, 8'd3, 8'd3, 2'b11, 2'b00, 2'b00, 1'b0);
    en_i = 2'b00;
    tick_in_i = 2'b00;
    tout0 = 2'b00;
    tout1 = 2'b00;
    clr_i = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    cyc += 10;
    repeat (3) step(2'b11, 8'd3, 8'd3, 2'b11, 2'b00, 2'b00, 1'b0);
    check("post_rst_no_tick", 32'(exp0), 0);
    step(2'b11, 8'd3, 8'd3, 2'b11, 2'b00, 2'b00, 1'b0);
    check("post_rst_tick", 32'(exp0), 32'h3);
    repeat (4) step(2'b11, 8'd3, 8'd3, 2'b00, 2'b00, 2'b00, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
